plic_hart_if: RTL and testbench
===============================

Name: plic_hart_if

Overview:
- Hart-side initiator for the PLIC configuration bus and interrupt handshake.
- Watches the PLIC's per-hart interrupt line and performs a claim read of the target's claim register. It then presents the claimed ID to the core trap logic as a machine external interrupt.
- When the core reports that the handler has finished, it performs the completion write and pulses the PLIC's complete input.
- Sits between one PLIC target port and one core.

Parameters:
- PLIC_BASE, 32'h0C00_0000, base address of the PLIC window on the config bus.
- TARGET_ID, 0, hart/target index. Claim address = PLIC_BASE + 32'h0020_0004 + TARGET_ID*4.
- ID_BITS, 5, significant claim-ID bits. Higher cfg_rdata bits are ignored.
- TIMEOUT_CYCLES, 64, cycles allowed from request to cfg_ready before abort. Range 2..1023.
- HOLDOFF_CYCLES, 2, idle cycles after a completion before a new claim may start. Minimum 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- enable_i, input, 1, permits new claims. Does not abort a claim already in progress.
- irq_i, input, 1, level interrupt request from the PLIC target output.
- cfg_en, output, 1, single-cycle request strobe.
- cfg_we, output, 1, 1 = write, 0 = read. Held until cfg_ready.
- cfg_addr, output, 32, transaction address. Held until cfg_ready.
- cfg_wdata, output, 32, write data. Held until cfg_ready.
- cfg_rdata, input, 32, read data. Valid while cfg_ready = 1.
- cfg_ready, input, 1, one-cycle response pulse from the PLIC.
- meip_o, output, 1, machine external interrupt pending to the core.
- irq_id_o, output, ID_BITS, claimed ID while meip_o or service is active, else 0.
- irq_done_i, input, 1, pulse from the core: external handler finished.
- irq_complete_o, output, 1, one-cycle pulse to the PLIC complete input.
- busy_o, output, 1, high in any state other than IDLE.
- timeout_err_o, output, 1, sticky bus-timeout flag.
- err_clr_i, input, 1, clears timeout_err_o.
- spurious_cnt_o, output, 8, count of claims that returned ID 0. Saturates at 255.

Behaviour:
- Reset (async, rst = 1):
  - State goes to IDLE.
  - All outputs are 0; cfg_addr and cfg_wdata are 0.
  - Timeout and holdoff counters are cleared.
  - A transaction in flight is abandoned; cfg_en drops immediately.
- All outputs are registered.
- States: IDLE, CLAIM_WAIT, SERVICE, CMPL_WAIT, HOLDOFF.
- IDLE:
  - If irq_i & enable_i: set cfg_en = 1, cfg_we = 0, cfg_addr = claim address, clear the timeout counter, go to CLAIM_WAIT.
- Bus rules:
  - cfg_en is high for exactly one cycle per transaction.
  - cfg_we, cfg_addr and cfg_wdata stay stable until the cycle after cfg_ready is sampled high.
  - cfg_ready seen in IDLE, SERVICE or HOLDOFF is ignored.
- CLAIM_WAIT, on cfg_ready = 1, with id = cfg_rdata[ID_BITS-1:0]:
  - id != 0: latch irq_id_o = id, set meip_o = 1, go to SERVICE. meip_o rises on the edge that samples cfg_ready. With the PLIC's 3-cycle responder this is 4 cycles after cfg_en.
  - id == 0: spurious. Increment spurious_cnt_o (saturating), no meip_o, go to HOLDOFF.
- SERVICE:
  - Waits indefinitely for irq_done_i.
  - irq_i and enable_i are ignored in this state.
  - irq_done_i in any other state is ignored.
- On irq_done_i in SERVICE:
  - meip_o = 0.
  - Issue a write: cfg_en = 1, cfg_we = 1, cfg_addr = claim address, cfg_wdata = zero-extended irq_id_o.
  - Clear the timeout counter, go to CMPL_WAIT.
- CMPL_WAIT, on cfg_ready:
  - irq_complete_o = 1 for one cycle.
  - irq_id_o = 0.
  - Load the holdoff counter, go to HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES, then returns to IDLE.
  - Gives the PLIC's irq_o time to fall, which prevents re-claiming the same source.
- Timeout:
  - The counter increments in CLAIM_WAIT and CMPL_WAIT.
  - When it reaches TIMEOUT_CYCLES without cfg_ready, set timeout_err_o.
  - Claim timeout: go to HOLDOFF, meip_o stays 0.
  - Completion timeout: still pulse irq_complete_o so the PLIC releases, clear irq_id_o, go to HOLDOFF.
- cfg_ready arriving on the same cycle the timeout count is reached: treat as a success; no error.
- err_clr_i clears timeout_err_o. A simultaneous new timeout wins (flag stays 1).

Test Plan:
- Model PLIC returns claim 7 after 3 cycles. Expect:
  - one read with cfg_en high for 1 cycle and cfg_addr = 0x0C20_0004;
  - meip_o = 1 and irq_id_o = 7 four cycles after cfg_en;
  - after irq_done_i: a write of wdata 7 to the same address, one irq_complete_o pulse, and busy_o low HOLDOFF_CYCLES + 1 cycles later.
- Claim returns 0 → meip_o stays 0, spurious_cnt_o = 1, no completion write, IDLE again. After 256 spurious claims the counter reads 255.
- cfg_ready never asserts on a claim → timeout_err_o = 1 at cycle 64, busy_o then drops. err_clr_i → flag returns to 0.
- During SERVICE, drop enable_i and toggle irq_i → no new cfg_en. irq_done_i still produces the completion write.
- cfg_ready never asserts on the completion write → irq_complete_o pulses after the timeout, timeout_err_o = 1, irq_id_o = 0.
- Assert rst in CLAIM_WAIT and again in SERVICE → cfg_en, meip_o and irq_id_o go to 0 immediately (asynchronously). A late cfg_ready after reset is ignored.

Source files
------------

// File: rtl/plic_hart_if_if.sv
// Config bus between the hart-side PLIC initiator and one PLIC target port.
// The master drives single-cycle requests; the slave answers with a ready pulse.
interface plic_hart_if_if;
  logic        cfg_en;
  logic        cfg_we;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;

  modport master (
    output cfg_en,
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    input  cfg_rdata,
    input  cfg_ready
  );

  modport slave (
    input  cfg_en,
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    output cfg_rdata,
    output cfg_ready
  );
endinterface

// File: rtl/plic_hart_if.sv
// Hart-side PLIC initiator: claims on irq, raises meip, completes on done.
// Bus timeouts abort to a holdoff window so the PLIC line can settle.
module plic_hart_if #(
  parameter logic [31:0] PLIC_BASE      = 32'h0C00_0000,
  parameter int unsigned TARGET_ID      = 0,
  parameter int unsigned ID_BITS        = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic               irq_i,
  plic_hart_if_if.master     cfg,
  output logic               meip_o,
  output logic [ID_BITS-1:0] irq_id_o,
  input  logic               irq_done_i,
  output logic               irq_complete_o,
  output logic               busy_o,
  output logic               timeout_err_o,
  input  logic               err_clr_i,
  output logic [7:0]         spurious_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_WAIT,
    SERVICE,
    CMPL_WAIT,
    HOLDOFF
  } state_t;

  localparam logic [31:0] CLAIM_ADDR =
    PLIC_BASE + 32'h0020_0004 + 32'(TARGET_ID * 4);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HO_LOAD = HW'(HOLDOFF_CYCLES);

  state_t              state_q, state_d;
  logic                en_q, en_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                meip_q, meip_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic                cmpl_q, cmpl_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [7:0]          spur_q, spur_d;
  logic [9:0]          tcnt_q, tcnt_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [ID_BITS-1:0]  rid;
  logic                unused_rdata;

  assign rid = cfg.cfg_rdata[ID_BITS-1:0];
  assign unused_rdata = ^cfg.cfg_rdata[31:ID_BITS];

  // Next-state and registered-output decode; ready beats timeout.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    meip_d  = meip_q;
    id_d    = id_q;
    cmpl_d  = 1'b0;
    err_d   = err_q;
    spur_d  = spur_q;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    if (err_clr_i) err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (irq_i && enable_i) begin
          en_d    = 1'b1;
          we_d    = 1'b0;
          addr_d  = CLAIM_ADDR;
          tcnt_d  = '0;
          state_d = CLAIM_WAIT;
        end
      end
      CLAIM_WAIT: begin
        if (cfg.cfg_ready) begin
          if (rid != '0) begin
            id_d    = rid;
            meip_d  = 1'b1;
            state_d = SERVICE;
          end else begin
            if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
            hcnt_d  = HO_LOAD;
            state_d = HOLDOFF;
          end
        end else if (tcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          hcnt_d  = HO_LOAD;
          state_d = HOLDOFF;
        end else begin
          tcnt_d = tcnt_q + 10'd1;
        end
      end
      SERVICE: begin
        if (irq_done_i) begin
          meip_d  = 1'b0;
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = CLAIM_ADDR;
          wdata_d = 32'(id_q);
          tcnt_d  = '0;
          state_d = CMPL_WAIT;
        end
      end
      CMPL_WAIT: begin
        if (cfg.cfg_ready || tcnt_q == TO_LAST) begin
          if (!cfg.cfg_ready) err_d = 1'b1;
          cmpl_d  = 1'b1;
          id_d    = '0;
          hcnt_d  = HO_LOAD;
          state_d = HOLDOFF;
        end else begin
          tcnt_d = tcnt_q + 10'd1;
        end
      end
      HOLDOFF: begin
        if (hcnt_q == '0) state_d = IDLE;
        else hcnt_d = hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any bus transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      meip_q  <= 1'b0;
      id_q    <= '0;
      cmpl_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      spur_q  <= '0;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      meip_q  <= meip_d;
      id_q    <= id_d;
      cmpl_q  <= cmpl_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      spur_q  <= spur_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign cfg.cfg_en      = en_q;
  assign cfg.cfg_we      = we_q;
  assign cfg.cfg_addr    = addr_q;
  assign cfg.cfg_wdata   = wdata_q;
  assign meip_o          = meip_q;
  assign irq_id_o        = id_q;
  assign irq_complete_o  = cmpl_q;
  assign busy_o          = busy_q;
  assign timeout_err_o   = err_q;
  assign spurious_cnt_o  = spur_q;

endmodule

// File: tb/tb_plic_hart_if.sv
// Scoreboard bench for plic_hart_if with a modelled PLIC responder.
// Expected bus/meip/complete events are queued; a monitor pops them.
module tb_plic_hart_if;
  localparam logic [31:0] CLAIM = 32'h0C20_0004;
  localparam int TO = 64;
  localparam int HO = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic       irq_i;
  logic       meip_o;
  logic [4:0] irq_id_o;
  logic       irq_done_i;
  logic       irq_complete_o;
  logic       busy_o;
  logic       timeout_err_o;
  logic       err_clr_i;
  logic [7:0] spurious_cnt_o;

  int          errors = 0;
  int          checks = 0;
  ev_t         sb[$];
  int          spur_m = 0;
  int          rsp_lat = 0;
  logic [31:0] rsp_data = 0;
  int          rsp_cnt = 0;
  bit          rsp_pend = 0;

  plic_hart_if_if bus();

  plic_hart_if #(
    .PLIC_BASE(32'h0C00_0000),
    .TARGET_ID(0),
    .ID_BITS(5),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable_i(enable_i),
    .irq_i(irq_i),
    .cfg(bus),
    .meip_o(meip_o),
    .irq_id_o(irq_id_o),
    .irq_done_i(irq_done_i),
    .irq_complete_o(irq_complete_o),
    .busy_o(busy_o),
    .timeout_err_o(timeout_err_o),
    .err_clr_i(err_clr_i),
    .spurious_cnt_o(spurious_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit sig(input int s);
    case (s)
      0: return timeout_err_o;
      1: return meip_o;
      2: return irq_complete_o;
      3: return !busy_o;
      default: return bus.cfg_en;
    endcase
  endfunction

  task automatic wait_sig(input int s, input int limit,
                          input string name, output int k);
    k = 0;
    while (!sig(s) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!sig(s)) begin
      checks++;
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, limit);
    end
  endtask

  // PLIC responder: ready pulse rsp_lat cycles after seeing cfg_en.
  initial begin
    bus.cfg_ready = 1'b0;
    bus.cfg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.cfg_ready = 1'b0;
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.cfg_ready = 1'b1;
          bus.cfg_rdata = rsp_data;
          rsp_pend = 0;
        end
      end
      if (bus.cfg_en && !rst && rsp_lat > 0) begin
        rsp_pend = 1;
        rsp_cnt = rsp_lat;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  initial begin
    logic pe, pm, pc;
    ev_t  e;
    pe = 0;
    pm = 0;
    pc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pe = 0;
        pm = 0;
        pc = 0;
      end else begin
        if (bus.cfg_en) begin
          check("en_single", {31'b0, pe}, 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_bus: got we=%0b addr=%0h expected none",
                     bus.cfg_we, bus.cfg_addr);
          end else begin
            e = sb.pop_front();
            check("bus_kind", {31'b0, bus.cfg_we}, e.kind);
            check("bus_addr", bus.cfg_addr, e.addr);
            if (e.kind == 1) check("bus_wdata", bus.cfg_wdata, e.data);
          end
        end
        if (meip_o && !pm) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_meip: got id=%0d expected none", irq_id_o);
          end else begin
            e = sb.pop_front();
            check("meip_kind", 2, e.kind);
            check("meip_id", {27'b0, irq_id_o}, e.data);
          end
        end
        if (irq_complete_o) begin
          check("cmpl_single", {31'b0, pc}, 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_cmpl: got pulse expected none");
          end else begin
            e = sb.pop_front();
            check("cmpl_kind", 3, e.kind);
            check("cmpl_id", {27'b0, irq_id_o}, 0);
          end
        end
        pe = bus.cfg_en;
        pm = meip_o;
        pc = irq_complete_o;
      end
    end
  end

  task automatic start_claim(input logic [31:0] rdata, input int lat);
    int k;
    wait_sig(3, 200, "idle", k);
    rsp_lat = lat;
    rsp_data = rdata;
    sb.push_back('{0, CLAIM, 0});
    if (lat > 0 && rdata[4:0] != 0)
      sb.push_back('{2, 0, {27'b0, rdata[4:0]}});
    irq_i = 1;
    enable_i = 1;
    @(negedge clk);
    wait_sig(4, 20, "claim_en", k);
    irq_i = 0;
  endtask

  task automatic episode(input logic [31:0] rdata, input int lat1,
                         input int lat2, input int svc,
                         input bit quiet, input bit hold_clr);
    int k;
    logic [4:0] id;
    id = rdata[4:0];
    err_clr_i = hold_clr;
    start_claim(rdata, lat1);
    if (lat1 == 0) begin
      wait_sig(0, TO + 10, "claim_to", k);
      check("claim_to_lat", k, TO);
      check("claim_to_meip", {31'b0, meip_o}, 0);
      if (hold_clr) begin
        @(negedge clk);
        check("err_clr_hold", {31'b0, timeout_err_o}, 0);
        err_clr_i = 0;
      end else begin
        wait_sig(3, 10, "claim_to_idle", k);
        check("claim_to_hold", k, HO + 1);
        check("err_sticky", {31'b0, timeout_err_o}, 1);
        err_clr_i = 1;
        @(negedge clk);
        err_clr_i = 0;
        check("err_clr", {31'b0, timeout_err_o}, 0);
      end
    end else if (id == 0) begin
      if (spur_m < 255) spur_m++;
      wait_sig(3, lat1 + HO + 10, "spur_idle", k);
      check("spur_cnt", {24'b0, spurious_cnt_o}, spur_m);
      check("spur_meip", {31'b0, meip_o}, 0);
    end else begin
      wait_sig(1, lat1 + 10, "meip_wait", k);
      check("meip_lat", k, lat1 + 1);
      check("no_err", {31'b0, timeout_err_o}, 0);
      if (quiet) enable_i = 0;
      for (int i = 0; i < svc; i++) begin
        if (quiet) irq_i = ~irq_i;
        @(negedge clk);
      end
      irq_i = 0;
      check("svc_id", {27'b0, irq_id_o}, {27'b0, id});
      check("svc_busy", {31'b0, busy_o}, 1);
      rsp_lat = lat2;
      sb.push_back('{1, CLAIM, {27'b0, id}});
      sb.push_back('{3, 0, 0});
      irq_done_i = 1;
      @(negedge clk);
      irq_done_i = 0;
      wait_sig(4, 20, "cmpl_en", k);
      check("meip_clr", {31'b0, meip_o}, 0);
      wait_sig(2, TO + 10, "cmpl_wait", k);
      if (lat2 == 0) begin
        check("cmpl_to_lat", k, TO);
        check("cmpl_to_err", {31'b0, timeout_err_o}, 1);
      end else begin
        check("cmpl_lat", k, lat2 + 1);
        check("cmpl_no_err", {31'b0, timeout_err_o}, 0);
      end
      wait_sig(3, 10, "hold", k);
      check("holdoff_len", k, HO + 1);
      enable_i = 1;
      if (lat2 == 0) begin
        err_clr_i = 1;
        @(negedge clk);
        err_clr_i = 0;
        check("err_clr2", {31'b0, timeout_err_o}, 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    sb.delete();
    spur_m = 0;
  endtask

  task automatic reset_mid(input bit in_service);
    int k;
    start_claim(32'h0000_0003, 5);
    if (in_service) wait_sig(1, 20, "rst_meip", k);
    #2;
    rst = 1;
    #1;
    check("rst_en", {31'b0, bus.cfg_en}, 0);
    check("rst_meip", {31'b0, meip_o}, 0);
    check("rst_id", {27'b0, irq_id_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    @(negedge clk);
    rst = 0;
    sb.delete();
    spur_m = 0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("late_rdy_busy", {31'b0, busy_o}, 0);
    check("late_rdy_meip", {31'b0, meip_o}, 0);
  endtask

  initial begin
    rst = 1;
    enable_i = 0;
    irq_i = 0;
    irq_done_i = 0;
    err_clr_i = 0;
    @(negedge clk);
    @(negedge clk);
    check("r_en", {31'b0, bus.cfg_en}, 0);
    check("r_we", {31'b0, bus.cfg_we}, 0);
    check("r_addr", bus.cfg_addr, 0);
    check("r_wdata", bus.cfg_wdata, 0);
    check("r_meip", {31'b0, meip_o}, 0);
    check("r_id", {27'b0, irq_id_o}, 0);
    check("r_cmpl", {31'b0, irq_complete_o}, 0);
    check("r_busy", {31'b0, busy_o}, 0);
    check("r_err", {31'b0, timeout_err_o}, 0);
    check("r_spur", {24'b0, spurious_cnt_o}, 0);
    rst = 0;
    @(negedge clk);

    episode(32'h0000_0007, 3, 3, 4, 0, 0);
    episode(32'hFFFF_FFE0, 3, 3, 0, 0, 0);
    episode(32'h0000_0004, 0, 0, 0, 0, 0);
    episode(32'h0000_0004, 0, 0, 0, 0, 1);
    episode(32'h0000_0005, 2, 2, 6, 1, 0);
    episode(32'h0000_0009, 3, 0, 1, 0, 0);
    episode(32'hABCD_E00C, 63, 63, 2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] rd;
      int l1, l2;
      rd = $urandom;
      l1 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      l2 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
      episode(rd, l1, l2, $urandom_range(0, 5),
              1'($urandom_range(0, 1)), 0);
    end

    reset_mid(0);
    reset_mid(1);

    do_reset();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] rd;
      rd = $urandom & 32'hFFFF_FFE0;
      episode(rd, $urandom_range(1, 3), 1, 0, 0, 0);
    end
    check("spur_sat", {24'b0, spurious_cnt_o}, 255);

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
